// File: rtl/nand3_vector_checker.sv
// Exhaustive tester for a 3-input NAND stage: drives all 8 vectors, checks the gate's output, and reports pass/fail.
// Latency: each vector is held SETTLE_CYCLES+1 cycles, so done rises 8*(SETTLE_CYCLES+1) edges after the start edge.
// Backpressure: none. start is ignored while a sweep runs and is not queued. Results hold until the next start.
// Optional: define NAND_CHK_HALT_ON_FAIL_EN to end the sweep on the first mismatching vector.
module nand3_vector_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             in_a,
  output logic             in_b,
  output logic             in_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sample;
  logic             exp_out;
  logic             mismatch;
  logic             halt_hit;
  logic             last;
  logic             start_ok;

  assign {in_a, in_b, in_c} = vec_q;

  // Sample decision for the current vector and the sweep-termination condition.
  always_comb begin
    sample   = (state_q == RUN) && (cnt_q == SETTLE_C);
    exp_out  = ~(&vec_q);
    // X or Z from the gate under test must count as a failure.
    mismatch = sample && (dut_out !== exp_out);
`ifdef NAND_CHK_HALT_ON_FAIL_EN
    halt_hit = mismatch;
`else
    halt_hit = 1'b0;
`endif
    last     = sample && ((vec_q == 3'd7) || halt_hit);
    start_ok = start && (state_q != RUN);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a start seen during RUN is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state; pass is only meaningful once done.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_count == '0);
  end

  // Vector stepping, settle counting, and error/first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q      <= 3'd0;
      cnt_q      <= '0;
      err_count  <= '0;
      fail_vec   <= 3'd0;
      fail_valid <= 1'b0;
    end else if (start_ok) begin
      vec_q      <= 3'd0;
      cnt_q      <= '0;
      err_count  <= '0;
      fail_vec   <= 3'd0;
      fail_valid <= 1'b0;
    end else if (state_q == RUN) begin
      if (!sample) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          if (!fail_valid) begin
            fail_vec   <= vec_q;
            fail_valid <= 1'b1;
          end
        end
        // The final vector (or the halting one) stays on the gate inputs.
        if (!last) vec_q <= vec_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_nand3_vector_checker.sv
module tb_nand3_vector_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  int         mode;
  int         n_checks;
  int         n_err;

  // Main instance: SETTLE_CYCLES=1, ERR_W=4.
  logic       a1, b1, c1, busy1, done1, pass1, fv1, g1;
  logic [3:0] err1;
  logic [2:0] fvec1;

  // Narrow-counter instance: ERR_W=2 to exercise saturation.
  logic       a2, b2, c2, busy2, done2, pass2, fv2, g2;
  logic [1:0] err2;
  logic [2:0] fvec2;

  nand3_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(g1),
    .in_a(a1), .in_b(b1), .in_c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fvec1), .fail_valid(fv1)
  );

  nand3_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(g2),
    .in_a(a2), .in_b(b2), .in_c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fvec2), .fail_valid(fv2)
  );

  // Gate models: 0 correct NAND, 1 stuck-at-1, 2 AND, 3 NAND wrong only at 010.
  function automatic logic gate(input int m, input logic [2:0] v);
    case (m)
      1:       return 1'b1;
      2:       return &v;
      3:       return (v == 3'b010) ? 1'b0 : ~(&v);
      default: return ~(&v);
    endcase
  endfunction

  assign g1 = gate(mode, {a1, b1, c1});
  assign g2 = gate(mode, {a2, b2, c2});

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the start edge (edge k).
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    mode     = 0;
    start    = 1'b0;
    rst_n    = 1'b0;
    #3;
    check("reset_flags", {busy1, done1, pass1, fv1, a1, b1, c1}, 0);
    check("reset_err_vec", {err1, fvec1}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("idle_no_activity", {busy1, done1, a1, b1, c1}, 0);

    // 1: correct NAND, vectors step every 2 cycles, done at k+16.
    pulse_start();
    check("t1_start_edge", {busy1, done1, a1, b1, c1}, 7'b10_000);
    for (int i = 1; i < 8; i++) begin
      tick(2);
      check($sformatf("t1_vec%0d", i), {busy1, a1, b1, c1}, {1'b1, 3'(i)});
    end
    tick(1);
    check("t1_k15_busy", {busy1, done1}, 2'b10);
    tick(1);
    check("t1_k16_done", {busy1, done1, pass1, fv1}, 4'b0110);
    check("t1_err", err1, 0);
    check("t1_hold111", {a1, b1, c1}, 3'b111);

    // 2: stuck-at-1, only 111 mismatches.
    mode = 1;
    pulse_start();
    tick(16);
    check("t2_flags", {done1, pass1, fv1}, 3'b101);
    check("t2_err", err1, 1);
    check("t2_fvec", fvec1, 3'b111);
    check("t2_err_w2", err2, 1);

    // Start in DONE clears results and restarts from 000.
    mode = 0;
    pulse_start();
    check("restart_clear", {busy1, done1, pass1, fv1, a1, b1, c1}, 7'b1000_000);
    check("restart_err_fvec", {err1, fvec1}, 0);
    tick(16);
    check("restart_pass", {done1, pass1}, 2'b11);

`ifdef NAND_CHK_HALT_ON_FAIL_EN
    // 6: halt on first failure at vector 010 (sampled at k+6).
    mode = 3;
    pulse_start();
    tick(5);
    check("t6_k5_running", {busy1, done1}, 2'b10);
    tick(1);
    check("t6_halt_done", {busy1, done1, pass1}, 3'b010);
    check("t6_in_hold", {a1, b1, c1}, 3'b010);
    check("t6_err", err1, 1);
    check("t6_fvec", {fv1, fvec1}, 4'b1010);
`else
    // 3: AND gate mismatches everywhere; narrow counter saturates.
    mode = 2;
    pulse_start();
    tick(16);
    check("t3_err", err1, 8);
    check("t3_fvec", {fv1, fvec1}, 4'b1000);
    check("t3_pass", {done1, pass1}, 2'b10);
    check("t3_err_sat_w2", err2, 3);

    // Single wrong vector, full sweep still runs.
    mode = 3;
    pulse_start();
    tick(15);
    check("t3b_k15_busy", {busy1, done1}, 2'b10);
    tick(1);
    check("t3b_err", err1, 1);
    check("t3b_fvec", {fv1, fvec1}, 4'b1010);
`endif

    // 4: start re-pulsed at vector 3 is ignored.
    mode = 0;
    pulse_start();
    tick(6);
    check("t4_vec3", {busy1, a1, b1, c1}, 4'b1011);
    pulse_start();
    check("t4_no_restart", {busy1, a1, b1, c1}, 4'b1011);
    tick(8);
    check("t4_k15", {busy1, done1}, 2'b10);
    tick(1);
    check("t4_on_schedule", {busy1, done1, pass1}, 3'b011);

    // 5: async reset while vector 4 is driven.
    mode = 1;
    pulse_start();
    tick(8);
    check("t5_vec4", {busy1, a1, b1, c1}, 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_flags", {busy1, done1, pass1, fv1, a1, b1, c1}, 0);
    check("t5_async_err", {err1, fvec1}, 0);
    #2;
    rst_n = 1'b1;
    tick(4);
    check("t5_idle_after", {busy1, done1, pass1, a1, b1, c1}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
